// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: ALU op classes,
// opcodes, state codes and the one-hot instruction-class bit positions.
package multicycle_controller_pkg;

  localparam logic [1:0] ALU_OP_MTYPE = 2'b00;
  localparam logic [1:0] ALU_OP_BTYPE = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FUNC_JR = 6'b001000;

  // Bit positions inside the decoder's one-hot instruction-class vector
  localparam int CLS_R    = 0;
  localparam int CLS_JR   = 1;
  localparam int CLS_LW   = 2;
  localparam int CLS_SW   = 3;
  localparam int CLS_BEQ  = 4;
  localparam int CLS_ADDI = 5;
  localparam int CLS_J    = 6;
  localparam int CLS_JAL  = 7;
  localparam int CLS_W    = 8;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_IF   = 4'd1,
    S_ID   = 4'd2,
    S_ADDR = 4'd3,
    S_MRD  = 4'd4,
    S_WBM  = 4'd5,
    S_MWR  = 4'd6,
    S_EXR  = 4'd7,
    S_WBR  = 4'd8,
    S_EXI  = 4'd9,
    S_WBI  = 4'd10,
    S_BEQ  = 4'd11,
    S_J    = 4'd12,
    S_JAL  = 4'd13,
    S_JR   = 4'd14
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_controller_opcode_decoder.sv
// Combinational opcode/func decode into a one-hot instruction class;
// illegal is raised when no supported class matches.
module multicycle_controller_opcode_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [5:0]        opcode,
  input  logic [5:0]        func,
  output logic [CLS_W-1:0]  inst_class,
  output logic              illegal
);

  // jr shares the R-type opcode, so func splits it off from the ALU R-types
  always_comb begin
    inst_class = '0;
    case (opcode)
      OP_RTYPE: begin
        if (func == FUNC_JR) inst_class[CLS_JR] = 1'b1;
        else                 inst_class[CLS_R]  = 1'b1;
      end
      OP_LW:   inst_class[CLS_LW]   = 1'b1;
      OP_SW:   inst_class[CLS_SW]   = 1'b1;
      OP_BEQ:  inst_class[CLS_BEQ]  = 1'b1;
      OP_ADDI: inst_class[CLS_ADDI] = 1'b1;
      OP_J:    inst_class[CLS_J]    = 1'b1;
      OP_JAL:  inst_class[CLS_JAL]  = 1'b1;
      default: inst_class = '0;
    endcase
  end

  assign illegal = ~|inst_class;

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS core. Control outputs are registered
// alongside the state, computed for the state being entered.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       illegal_op
);

  state_t             state_q, state_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic [CLS_W-1:0]   inst_class;
  logic               decode_illegal;
  logic               ready;
  logic               if_gate;
  logic               unused_zero;

  // zero only gates the branch in the datapath; the controller never looks at it
  assign unused_zero = zero;
  assign ready       = MEM_WAIT_EN ? mem_ready : 1'b1;

  multicycle_controller_opcode_decoder u_decoder (
    .opcode     (opcode),
    .func       (func),
    .inst_class (inst_class),
    .illegal    (decode_illegal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RST;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST: state_d = S_IF;
      S_IF:  if (ready) state_d = S_ID;
      S_ID: begin
        if (inst_class[CLS_LW] || inst_class[CLS_SW]) state_d = S_ADDR;
        else if (inst_class[CLS_JR])                  state_d = S_JR;
        else if (inst_class[CLS_R])                   state_d = S_EXR;
        else if (inst_class[CLS_BEQ])                 state_d = S_BEQ;
        else if (inst_class[CLS_ADDI])                state_d = S_EXI;
        else if (inst_class[CLS_J])                   state_d = S_J;
        else if (inst_class[CLS_JAL])                 state_d = S_JAL;
        else                                          state_d = S_IF;
      end
      S_ADDR: begin
        if (inst_class[CLS_LW])      state_d = S_MRD;
        else if (inst_class[CLS_SW]) state_d = S_MWR;
        else                         state_d = S_IF;
      end
      S_MRD: if (ready) state_d = S_WBM;
      S_MWR: if (ready) state_d = S_IF;
      S_EXR: state_d = S_WBR;
      S_EXI: state_d = S_WBI;
      S_WBM, S_WBR, S_WBI, S_BEQ, S_J, S_JAL, S_JR: state_d = S_IF;
      default: state_d = S_RST;
    endcase
  end

  // Outputs for the state about to be entered; illegal_op marks the ID->IF bailout
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_IF: begin
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.ir_write  = 1'b1;
        ctrl_d.pc_write  = 1'b1;
        ctrl_d.alu_src_b = 2'b01;
        ctrl_d.alu_op    = ALU_OP_MTYPE;
      end
      S_ID: begin
        ctrl_d.alu_src_b = 2'b11;
        ctrl_d.alu_op    = ALU_OP_MTYPE;
      end
      S_ADDR, S_EXI: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 2'b10;
        ctrl_d.alu_op    = ALU_OP_MTYPE;
      end
      S_MRD: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.i_or_d   = 1'b1;
      end
      S_WBM: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 2'b01;
      end
      S_MWR: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.i_or_d    = 1'b1;
      end
      S_EXR: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_op    = ALU_OP_RTYPE;
      end
      S_WBR: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.reg_dst   = 2'b01;
      end
      S_WBI: ctrl_d.reg_write = 1'b1;
      S_BEQ: begin
        ctrl_d.alu_src_a     = 1'b1;
        ctrl_d.alu_op        = ALU_OP_BTYPE;
        ctrl_d.pc_write_cond = 1'b1;
        ctrl_d.pc_src        = 2'b01;
      end
      S_J: begin
        ctrl_d.pc_write = 1'b1;
        ctrl_d.pc_src   = 2'b10;
      end
      S_JAL: begin
        ctrl_d.pc_write   = 1'b1;
        ctrl_d.pc_src     = 2'b10;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.reg_dst    = 2'b10;
        ctrl_d.mem_to_reg = 2'b10;
      end
      S_JR: begin
        ctrl_d.pc_write = 1'b1;
        ctrl_d.pc_src   = 2'b11;
      end
      default: ctrl_d = '0;
    endcase
    ctrl_d.illegal_op = (state_q == S_ID) && decode_illegal;
  end

  // The fetch only commits (PC and IR load) in the cycle memory answers
  assign if_gate = (state_q == S_IF) ? ready : 1'b1;

  assign pc_write      = ctrl_q.pc_write & if_gate;
  assign ir_write      = ctrl_q.ir_write & if_gate;
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign i_or_d        = ctrl_q.i_or_d;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign reg_dst       = ctrl_q.reg_dst;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign reg_write     = ctrl_q.reg_write;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign pc_src        = ctrl_q.pc_src;
  assign alu_op        = ctrl_q.alu_op;
  assign illegal_op    = ctrl_q.illegal_op;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected control vectors
// are queued as stimulus is driven and checked on the following falling edge.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic [1:0] reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src, alu_op;
  logic       illegal_op;

  typedef struct {
    string       tag;
    logic [18:0] exp;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [18:0] observed;

  logic [18:0] e_zero, e_if, e_if_wait, e_id, e_addr, e_mrd, e_wbm, e_mwr;
  logic [18:0] e_exr, e_wbr, e_exi, e_wbi, e_beq, e_j, e_jal, e_jr, e_ill;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .func          (func),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_src        (pc_src),
    .alu_op        (alu_op),
    .illegal_op    (illegal_op)
  );

  assign observed = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src,
                     alu_op, illegal_op};

  function automatic logic [18:0] vec(
    input logic pcw, input logic pcwc, input logic iord, input logic mr,
    input logic mw, input logic irw, input logic [1:0] rd, input logic [1:0] mtr,
    input logic rw, input logic asa, input logic [1:0] asb, input logic [1:0] pcs,
    input logic [1:0] aop, input logic ill);
    return {pcw, pcwc, iord, mr, mw, irw, rd, mtr, rw, asa, asb, pcs, aop, ill};
  endfunction

  task automatic check_output(input string tag, input logic [18:0] exp);
    tests_run++;
    assert (observed === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, exp);
    end
  endtask

  task automatic apply_stimulus(input string tag, input logic rdy, input logic [18:0] exp);
    @(posedge clk);
    #1;
    mem_ready = rdy;
    sb_q.push_back('{tag, exp});
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    func   = fn;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_entry_t e;
      e = sb_q.pop_front();
      check_output(e.tag, e.exp);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    e_zero    = '0;
    e_if      = vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0);
    e_if_wait = vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0);
    e_id      = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0);
    e_addr    = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0);
    e_mrd     = vec(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    e_wbm     = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    e_mwr     = vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    e_exr     = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 2'b10, 1'b0);
    e_wbr     = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    e_exi     = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0);
    e_wbi     = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    e_beq     = vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0);
    e_j       = vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0);
    e_jal     = vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0);
    e_jr      = vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00, 1'b0);
    e_ill     = e_if_wait | 19'd1;

    rst       = 1'b0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    set_instr(6'b000000, 6'b100000);
    #1;
    check_output("reset_async", e_zero);
    #11;
    rst = 1'b1;
    #1;
    check_output("reset_state", e_zero);

    // add: 4 cycles
    apply_stimulus("add_if", 1'b1, e_if);
    apply_stimulus("add_id", 1'b1, e_id);
    apply_stimulus("add_exr", 1'b1, e_exr);
    apply_stimulus("add_wbr", 1'b1, e_wbr);

    // lw with two wait cycles in S_MRD: 7 cycles
    set_instr(6'b100011, 6'b000000);
    apply_stimulus("lw_if", 1'b1, e_if);
    apply_stimulus("lw_id", 1'b1, e_id);
    apply_stimulus("lw_addr", 1'b1, e_addr);
    apply_stimulus("lw_mrd_wait0", 1'b0, e_mrd);
    apply_stimulus("lw_mrd_wait1", 1'b0, e_mrd);
    apply_stimulus("lw_mrd_done", 1'b1, e_mrd);
    apply_stimulus("lw_wbm", 1'b1, e_wbm);

    set_instr(6'b000100, 6'b000000);
    apply_stimulus("beq_if", 1'b1, e_if);
    apply_stimulus("beq_id", 1'b1, e_id);
    apply_stimulus("beq_exec", 1'b1, e_beq);

    set_instr(6'b000000, 6'b001000);
    apply_stimulus("jr_if", 1'b1, e_if);
    apply_stimulus("jr_id", 1'b1, e_id);
    apply_stimulus("jr_exec", 1'b1, e_jr);

    set_instr(6'b000011, 6'b000000);
    apply_stimulus("jal_if", 1'b1, e_if);
    apply_stimulus("jal_id", 1'b1, e_id);
    apply_stimulus("jal_exec", 1'b1, e_jal);

    // Unsupported opcode: pulse lands in the following fetch, which stalls once
    set_instr(6'b111111, 6'b000000);
    apply_stimulus("ill_if", 1'b1, e_if);
    apply_stimulus("ill_id", 1'b1, e_id);
    apply_stimulus("ill_pulse", 1'b0, e_ill);
    set_instr(6'b001000, 6'b000000);
    apply_stimulus("addi_if", 1'b1, e_if);
    apply_stimulus("addi_id", 1'b1, e_id);
    apply_stimulus("addi_exi", 1'b1, e_exi);
    apply_stimulus("addi_wbi", 1'b1, e_wbi);

    set_instr(6'b000010, 6'b000000);
    apply_stimulus("j_if", 1'b1, e_if);
    apply_stimulus("j_id", 1'b1, e_id);
    apply_stimulus("j_exec", 1'b1, e_j);

    set_instr(6'b101011, 6'b000000);
    apply_stimulus("sw_if_wait", 1'b0, e_if_wait);
    apply_stimulus("sw_if", 1'b1, e_if);
    apply_stimulus("sw_id", 1'b1, e_id);
    apply_stimulus("sw_addr", 1'b1, e_addr);
    apply_stimulus("sw_mwr_wait0", 1'b0, e_mwr);
    apply_stimulus("sw_mwr_wait1", 1'b0, e_mwr);

    // Abort the stalled store with an asynchronous reset
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_output("rst_abort", e_zero);
    @(posedge clk);
    #1;
    check_output("rst_hold", e_zero);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("rst_released", e_zero);
    set_instr(6'b000010, 6'b000000);
    apply_stimulus("post_rst_if", 1'b1, e_if);
    apply_stimulus("post_rst_id", 1'b1, e_id);
    apply_stimulus("post_rst_j", 1'b1, e_j);

    @(negedge clk);
    #1;
    tests_run++;
    assert (sb_q.size() === 0) else begin
      tests_failed++;
      $error("[TB] FAIL scoreboard_drain: observed %0d pending expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
